// File: rtl/pipe_hazard_ctl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctl
// Purpose  : Stall/flush controller for the 5-stage MIPS pipeline. Drives the
//            hold/clear inputs of the PC and the IF/ID, ID/EX, EX/MEM and
//            MEM/WB registers. It handles load-use and RAW hazards, taken
//            branches, multi-cycle mult/div occupancy of EX and memory wait.
// Options  : PIPE_FORWARD_EN - when defined, EX/MEM forwarding exists
//            elsewhere and only load-use hazards stall the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctl #(
  parameter int MD_CYCLES = 32,  // cycles a mult/div occupies EX (>= 2)
  parameter int CNT_W     = 32   // stall performance counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_dest,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_dest,
  input  logic             ex_is_md,
  input  logic             branch_taken,
  input  logic             mem_wait,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             memwb_hold,
  output logic             ifid_clear,
  output logic             idex_clear,
  output logic             exmem_clear,
  output logic             memwb_clear,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  // The trigger cycle is the first of MD_CYCLES; MD_BUSY covers the rest,
  // so the counter is loaded with MD_CYCLES-2 and the last cycle sees zero.
  localparam int              c_CW      = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_MD_LOAD = c_CW'(MD_CYCLES - 2);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [c_CW-1:0]  r_md_cnt;
  logic [c_CW-1:0]  w_md_cnt_nxt;
  logic             w_md_stall;
  logic             w_md_busy;
  logic             w_raw_ex;
  logic             w_raw_mem;
  logic             w_load_use;
  logic             w_data_stall;
  logic [CNT_W-1:0] r_stall_cnt;

  // Register $0 is hard-wired to zero, so a write to it is never a hazard.
  assign w_raw_ex  = ex_regwrite && (ex_dest != 5'd0) &&
                     ((id_use_rs && (id_rs == ex_dest)) ||
                      (id_use_rt && (id_rt == ex_dest)));
  assign w_raw_mem = mem_regwrite && (mem_dest != 5'd0) &&
                     ((id_use_rs && (id_rs == mem_dest)) ||
                      (id_use_rt && (id_rt == mem_dest)));
  assign w_load_use = w_raw_ex && ex_memread;

`ifdef PIPE_FORWARD_EN
  // Forwarding resolves ALU results; only a load's data arrives too late.
  assign w_data_stall = w_load_use;
`else
  // No forwarding: any pending EX/MEM write stalls. The register file's
  // write-first behaviour covers WB. load_use is a subset of raw_ex.
  assign w_data_stall = w_load_use || w_raw_ex || w_raw_mem;
`endif

  // State and mult/div occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // Next-state logic; the counter runs regardless of mem_wait.
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_md_stall   = 1'b0;
    w_md_busy    = 1'b0;
    case (r_state)
      RUN: begin
        if (ex_is_md) begin
          w_md_stall   = 1'b1;
          w_md_busy    = 1'b1;
          w_md_cnt_nxt = c_MD_LOAD;
          w_state_nxt  = MD_BUSY;
        end
      end
      MD_BUSY: begin
        w_md_busy = 1'b1;
        if (r_md_cnt != '0) begin
          w_md_stall   = 1'b1;
          w_md_cnt_nxt = r_md_cnt - c_CW'(1);
        end else begin
          // Last cycle: release unless memory still stalls the pipeline.
          w_state_nxt = mem_wait ? MD_DONE : RUN;
        end
      end
      MD_DONE: begin
        w_md_busy = 1'b1;
        if (mem_wait) begin
          w_md_stall = 1'b1;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // Prioritised hold/clear decode; reset forces bubbles everywhere.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_hold   = 1'b0;
    exmem_hold  = 1'b0;
    memwb_hold  = 1'b0;
    ifid_clear  = 1'b0;
    idex_clear  = 1'b0;
    exmem_clear = 1'b0;
    memwb_clear = 1'b0;
    md_busy     = 1'b0;
    if (rst) begin
      ifid_clear  = 1'b1;
      idex_clear  = 1'b1;
      exmem_clear = 1'b1;
      memwb_clear = 1'b1;
    end else begin
      md_busy = w_md_busy;
      if (mem_wait) begin
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_hold  = 1'b1;
        exmem_hold = 1'b1;
        memwb_hold = 1'b1;
      end else if (w_md_stall) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_hold   = 1'b1;
        exmem_clear = 1'b1;
      end else if (branch_taken) begin
        ifid_clear = 1'b1;
        idex_clear = 1'b1;
      end else if (w_data_stall) begin
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_clear = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (pc_hold && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctl
// Purpose  : Scoreboard bench for pipe_hazard_ctl. Directed vectors push the
//            expected hold/clear/md_busy vector and stall count into a queue;
//            a negedge monitor pops and compares each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctl;

  localparam int MDC   = 4;
  localparam int CW    = 4;
`ifdef PIPE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {pc,ifid,idex,exmem,memwb}_hold, {ifid,idex,exmem,memwb}_clear, md_busy
  localparam logic [9:0] O_NONE  = 10'b00000_0000_0;
  localparam logic [9:0] O_RST   = 10'b00000_1111_0;
  localparam logic [9:0] O_LU    = 10'b11000_0100_0;
  localparam logic [9:0] O_BR    = 10'b00000_1100_0;
  localparam logic [9:0] O_MD    = 10'b11100_0010_1;
  localparam logic [9:0] O_MDREL = 10'b00000_0000_1;
  localparam logic [9:0] O_MW    = 10'b11111_0000_0;
  localparam logic [9:0] O_MWMD  = 10'b11111_0000_1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    id_rs, id_rt, ex_dest, mem_dest;
  logic          id_use_rs, id_use_rt, ex_regwrite, ex_memread, mem_regwrite;
  logic          ex_is_md, branch_taken, mem_wait;
  logic          pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold;
  logic          ifid_clear, idex_clear, exmem_clear, memwb_clear, md_busy;
  logic [CW-1:0] stall_cycles;
  logic [9:0]    got;

  typedef struct {
    logic [9:0]    o;
    logic [CW-1:0] cnt;
    string         name;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  logic [CW-1:0] exp_cnt = '0;
  int            checks = 0;
  int            passes = 0;

  always #5 clk = ~clk;

  assign got = {pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold,
                ifid_clear, idex_clear, exmem_clear, memwb_clear, md_busy};

  pipe_hazard_ctl #(.MD_CYCLES(MDC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_dest(ex_dest),
    .mem_regwrite(mem_regwrite), .mem_dest(mem_dest),
    .ex_is_md(ex_is_md), .branch_taken(branch_taken), .mem_wait(mem_wait),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold),
    .exmem_hold(exmem_hold), .memwb_hold(memwb_hold),
    .ifid_clear(ifid_clear), .idex_clear(idex_clear),
    .exmem_clear(exmem_clear), .memwb_clear(memwb_clear),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  task automatic clr_in();
    id_rs = '0; id_rt = '0; ex_dest = '0; mem_dest = '0;
    id_use_rs = 0; id_use_rt = 0; ex_regwrite = 0; ex_memread = 0;
    mem_regwrite = 0; ex_is_md = 0; branch_taken = 0; mem_wait = 0;
  endtask

  // Advance to just after the next rising edge with inputs idle.
  task automatic tick();
    @(posedge clk);
    #1;
    clr_in();
  endtask

  // Push this cycle's expectation; the count seen is the pc_hold history.
  task automatic expect_o(input logic [9:0] o, input string nm);
    exp_t x;
    x.o = o;
    x.cnt = exp_cnt;
    x.name = nm;
    q.push_back(x);
    if (o[9] && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic set_lu();
    ex_memread = 1; ex_regwrite = 1; ex_dest = 5'd5; id_rs = 5'd5; id_use_rs = 1;
  endtask

  // Monitor: compare outputs mid-cycle against the scoreboard head.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (got !== e.o)
        $display("FAIL %s outputs got=%b exp=%b", e.name, got, e.o);
      else
        passes++;
      checks++;
      if (stall_cycles !== e.cnt)
        $display("FAIL %s stall_cycles got=%0d exp=%0d", e.name, stall_cycles, e.cnt);
      else
        passes++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clr_in();
    @(posedge clk); #1;
    exp_cnt = '0;                          expect_o(O_RST,  "reset");
    tick(); rst = 0;                       expect_o(O_NONE, "idle");
    tick(); set_lu();                      expect_o(O_LU,   "load_use");
    tick(); set_lu(); ex_dest = 0; id_rs = 0;
                                           expect_o(O_NONE, "zero_reg");
    tick(); set_lu(); branch_taken = 1;    expect_o(O_BR,   "branch_over_lu");
    tick(); set_lu(); id_use_rs = 0;       expect_o(O_NONE, "no_use");
    tick(); ex_regwrite = 1; ex_dest = 5'd7; id_rt = 5'd7; id_use_rt = 1;
                                           expect_o(FWD ? O_NONE : O_LU, "raw_ex");
    tick(); mem_regwrite = 1; mem_dest = 5'd8; id_rt = 5'd8; id_use_rt = 1;
                                           expect_o(FWD ? O_NONE : O_LU, "raw_mem");
    tick(); set_lu(); mem_wait = 1;        expect_o(O_MW,   "lu_memwait");
    tick(); set_lu();                      expect_o(O_LU,   "lu_after_mw");
    // mult/div alone: three stall cycles, release in the fourth
    tick(); ex_is_md = 1;                  expect_o(O_MD,    "md_c1");
    tick(); ex_is_md = 1; branch_taken = 1; expect_o(O_MD,   "md_c2_br_masked");
    tick(); ex_is_md = 1;                  expect_o(O_MD,    "md_c3");
    tick(); ex_is_md = 1;                  expect_o(O_MDREL, "md_release");
    tick();                                expect_o(O_NONE,  "md_run");
    // mult/div with mem_wait across the expiry
    tick(); ex_is_md = 1;                  expect_o(O_MD,    "mdw_c1");
    for (int i = 2; i <= 6; i++) begin
      tick(); ex_is_md = 1; mem_wait = 1;  expect_o(O_MWMD,  $sformatf("mdw_c%0d", i));
    end
    tick(); ex_is_md = 1;                  expect_o(O_MDREL, "mdw_release");
    tick();                                expect_o(O_NONE,  "mdw_run");
    // drive the 4-bit stall counter into saturation
    for (int i = 0; i < 4; i++) begin
      tick(); set_lu();                    expect_o(O_LU,    $sformatf("sat_lu%0d", i));
    end
    tick();                                expect_o(O_NONE,  "sat_hold");
    tick();                                expect_o(O_NONE,  "sat_hold2");
    // asynchronous reset in the middle of MD_BUSY
    tick(); ex_is_md = 1;                  expect_o(O_MD,    "rmd_c1");
    tick(); ex_is_md = 1;                  expect_o(O_MD,    "rmd_c2");
    tick(); ex_is_md = 1; rst = 1; exp_cnt = '0;
                                           expect_o(O_RST,   "rst_mid_md");
    tick();                                expect_o(O_RST,   "rst_held");
    tick(); rst = 0;                       expect_o(O_NONE,  "post_rst_run");
    tick(); set_lu();                      expect_o(O_LU,    "post_rst_lu");
    tick();                                expect_o(O_NONE,  "post_rst_cnt");
    tick();
    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
